// File: rtl/core_op_sched.sv
// core_op_sched: round-robin arbiter in front of a shared combinational core_op.
// Two requesters compete for a single issue stage that drives core_op. DIV
// operands are held for DIV_CYCLES cycles so the divide path can be treated as
// multicycle. The result is then captured into a valid/ready output register.

package core_op_pkg;
  localparam int OP_SIZE = 3;
  localparam logic [OP_SIZE-1:0] ADD = 3'd0;
  localparam logic [OP_SIZE-1:0] SUB = 3'd1;
  localparam logic [OP_SIZE-1:0] MUL = 3'd2;
  localparam logic [OP_SIZE-1:0] DIV = 3'd3;

  // Total exponent: regime range plus exponent bits plus sign headroom.
  function automatic int te_size(input int n);
    return $clog2(n) + 3;
  endfunction

  // Mantissa including the hidden bit.
  function automatic int mant_size(input int n);
    return n - 2;
  endfunction

  // Full-width fraction result (product width).
  function automatic int frac_full_size(input int n);
    return 2 * (n - 2);
  endfunction
endpackage

module core_op_sched
  import core_op_pkg::*;
#(
  parameter int N          = 16,
  parameter int TAG_W      = 4,
  parameter int DIV_CYCLES = 3,
  localparam int TE_SIZE        = te_size(N),
  localparam int MANT_SIZE      = mant_size(N),
  localparam int FRAC_FULL_SIZE = frac_full_size(N)
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  req_valid,
  output logic [1:0]                  req_ready,
  input  logic [2*OP_SIZE-1:0]        req_op,
  input  logic [1:0]                  req_sign1,
  input  logic [1:0]                  req_sign2,
  input  logic [2*TE_SIZE-1:0]        req_te1,
  input  logic [2*TE_SIZE-1:0]        req_te2,
  input  logic [2*MANT_SIZE-1:0]      req_mant1,
  input  logic [2*MANT_SIZE-1:0]      req_mant2,
  input  logic [2*TAG_W-1:0]          req_tag,
  output logic [OP_SIZE-1:0]          cop_op,
  output logic                        cop_sign1,
  output logic                        cop_sign2,
  output logic [TE_SIZE-1:0]          cop_te1,
  output logic [TE_SIZE-1:0]          cop_te2,
  output logic [MANT_SIZE-1:0]        cop_mant1,
  output logic [MANT_SIZE-1:0]        cop_mant2,
  input  logic [TE_SIZE-1:0]          cop_te_out,
  input  logic [FRAC_FULL_SIZE-1:0]   cop_frac_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TE_SIZE-1:0]          out_te,
  output logic [FRAC_FULL_SIZE-1:0]   out_frac,
  output logic                        out_id,
  output logic [TAG_W-1:0]            out_tag,
  output logic                        busy
);

  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  // Anything that is not ADD/SUB/MUL goes down core_op's default (divide) path.
  function automatic logic is_div(input logic [OP_SIZE-1:0] op);
    return !((op == ADD) || (op == SUB) || (op == MUL));
  endfunction

  logic                      rr_q, rr_d;
  logic                      issue_valid_q, issue_valid_d;
  logic [3:0]                div_cnt_q, div_cnt_d;
  logic [OP_SIZE-1:0]        iss_op_q, iss_op_d;
  logic                      iss_sign1_q, iss_sign1_d;
  logic                      iss_sign2_q, iss_sign2_d;
  logic [TE_SIZE-1:0]        iss_te1_q, iss_te1_d;
  logic [TE_SIZE-1:0]        iss_te2_q, iss_te2_d;
  logic [MANT_SIZE-1:0]      iss_mant1_q, iss_mant1_d;
  logic [MANT_SIZE-1:0]      iss_mant2_q, iss_mant2_d;
  logic                      iss_id_q, iss_id_d;
  logic [TAG_W-1:0]          iss_tag_q, iss_tag_d;
  logic                      out_valid_q, out_valid_d;
  logic [TE_SIZE-1:0]        out_te_q, out_te_d;
  logic [FRAC_FULL_SIZE-1:0] out_frac_q, out_frac_d;
  logic                      out_id_q, out_id_d;
  logic [TAG_W-1:0]          out_tag_q, out_tag_d;

  logic gnt_idx;
  logic in_ready;
  logic accept;
  logic exec_done;
  logic issue_adv;
  logic [OP_SIZE-1:0] sel_op;

  // Handshake control: grant selection, advance condition and requester accept.
  always_comb begin
    exec_done = issue_valid_q & (div_cnt_q == 4'd0);
    issue_adv = exec_done & (~out_valid_q | out_ready);
    in_ready  = ~issue_valid_q | issue_adv;
    gnt_idx   = (&req_valid) ? rr_q : req_valid[1];
    accept    = (|req_valid) & in_ready & ~rst;
    req_ready = 2'b00;
    if (accept) req_ready = gnt_idx ? 2'b10 : 2'b01;
    sel_op    = gnt_idx ? req_op[OP_SIZE +: OP_SIZE] : req_op[0 +: OP_SIZE];
    rr_d      = accept ? ~gnt_idx : rr_q;
  end

  // Issue stage: load on accept, otherwise hold and count down a DIV window.
  always_comb begin
    issue_valid_d = issue_valid_q;
    div_cnt_d     = div_cnt_q;
    iss_op_d      = iss_op_q;
    iss_sign1_d   = iss_sign1_q;
    iss_sign2_d   = iss_sign2_q;
    iss_te1_d     = iss_te1_q;
    iss_te2_d     = iss_te2_q;
    iss_mant1_d   = iss_mant1_q;
    iss_mant2_d   = iss_mant2_q;
    iss_id_d      = iss_id_q;
    iss_tag_d     = iss_tag_q;
    if (accept) begin
      issue_valid_d = 1'b1;
      div_cnt_d     = is_div(sel_op) ? DIV_LOAD : 4'd0;
      iss_op_d      = sel_op;
      iss_id_d      = gnt_idx;
      iss_sign1_d   = gnt_idx ? req_sign1[1] : req_sign1[0];
      iss_sign2_d   = gnt_idx ? req_sign2[1] : req_sign2[0];
      iss_te1_d     = gnt_idx ? req_te1[TE_SIZE +: TE_SIZE] : req_te1[0 +: TE_SIZE];
      iss_te2_d     = gnt_idx ? req_te2[TE_SIZE +: TE_SIZE] : req_te2[0 +: TE_SIZE];
      iss_mant1_d   = gnt_idx ? req_mant1[MANT_SIZE +: MANT_SIZE] : req_mant1[0 +: MANT_SIZE];
      iss_mant2_d   = gnt_idx ? req_mant2[MANT_SIZE +: MANT_SIZE] : req_mant2[0 +: MANT_SIZE];
      iss_tag_d     = gnt_idx ? req_tag[TAG_W +: TAG_W] : req_tag[0 +: TAG_W];
    end else begin
      if (issue_adv) issue_valid_d = 1'b0;
      if (div_cnt_q != 4'd0) div_cnt_d = div_cnt_q - 4'd1;
    end
  end

  // Output register: capture core_op result on advance, drop on downstream accept.
  always_comb begin
    out_valid_d = out_valid_q;
    out_te_d    = out_te_q;
    out_frac_d  = out_frac_q;
    out_id_d    = out_id_q;
    out_tag_d   = out_tag_q;
    if (issue_adv) begin
      out_valid_d = 1'b1;
      out_te_d    = cop_te_out;
      out_frac_d  = cop_frac_out;
      out_id_d    = iss_id_q;
      out_tag_d   = iss_tag_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers, all cleared asynchronously so a reset drops in-flight work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q          <= 1'b0;
      issue_valid_q <= 1'b0;
      div_cnt_q     <= 4'd0;
      iss_op_q      <= '0;
      iss_sign1_q   <= 1'b0;
      iss_sign2_q   <= 1'b0;
      iss_te1_q     <= '0;
      iss_te2_q     <= '0;
      iss_mant1_q   <= '0;
      iss_mant2_q   <= '0;
      iss_id_q      <= 1'b0;
      iss_tag_q     <= '0;
      out_valid_q   <= 1'b0;
      out_te_q      <= '0;
      out_frac_q    <= '0;
      out_id_q      <= 1'b0;
      out_tag_q     <= '0;
    end else begin
      rr_q          <= rr_d;
      issue_valid_q <= issue_valid_d;
      div_cnt_q     <= div_cnt_d;
      iss_op_q      <= iss_op_d;
      iss_sign1_q   <= iss_sign1_d;
      iss_sign2_q   <= iss_sign2_d;
      iss_te1_q     <= iss_te1_d;
      iss_te2_q     <= iss_te2_d;
      iss_mant1_q   <= iss_mant1_d;
      iss_mant2_q   <= iss_mant2_d;
      iss_id_q      <= iss_id_d;
      iss_tag_q     <= iss_tag_d;
      out_valid_q   <= out_valid_d;
      out_te_q      <= out_te_d;
      out_frac_q    <= out_frac_d;
      out_id_q      <= out_id_d;
      out_tag_q     <= out_tag_d;
    end
  end

  assign cop_op    = iss_op_q;
  assign cop_sign1 = iss_sign1_q;
  assign cop_sign2 = iss_sign2_q;
  assign cop_te1   = iss_te1_q;
  assign cop_te2   = iss_te2_q;
  assign cop_mant1 = iss_mant1_q;
  assign cop_mant2 = iss_mant2_q;
  assign out_valid = out_valid_q;
  assign out_te    = out_te_q;
  assign out_frac  = out_frac_q;
  assign out_id    = out_id_q;
  assign out_tag   = out_tag_q;
  assign busy      = issue_valid_q | out_valid_q;

endmodule

// File: tb/tb_core_op_sched.sv
// Testbench for core_op_sched: randomized requesters and a stand-in core_op,
// checked every cycle against a slot-level reference model.
module tb_core_op_sched;
  import core_op_pkg::*;

  localparam int N          = 16;
  localparam int TAG_W      = 4;
  localparam int DIV_CYCLES = 3;
  localparam int TE         = te_size(N);
  localparam int MS         = mant_size(N);
  localparam int FS         = frac_full_size(N);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [2*OP_SIZE-1:0] req_op;
  logic [1:0]           req_sign1, req_sign2;
  logic [2*TE-1:0]      req_te1, req_te2;
  logic [2*MS-1:0]      req_mant1, req_mant2;
  logic [2*TAG_W-1:0]   req_tag;
  logic [OP_SIZE-1:0]   cop_op;
  logic                 cop_sign1, cop_sign2;
  logic [TE-1:0]        cop_te1, cop_te2;
  logic [MS-1:0]        cop_mant1, cop_mant2;
  logic [TE-1:0]        cop_te_out;
  logic [FS-1:0]        cop_frac_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [TE-1:0]        out_te;
  logic [FS-1:0]        out_frac;
  logic                 out_id;
  logic [TAG_W-1:0]     out_tag;
  logic                 busy;

  core_op_sched #(.N(N), .TAG_W(TAG_W), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_sign1(req_sign1), .req_sign2(req_sign2),
    .req_te1(req_te1), .req_te2(req_te2),
    .req_mant1(req_mant1), .req_mant2(req_mant2), .req_tag(req_tag),
    .cop_op(cop_op), .cop_sign1(cop_sign1), .cop_sign2(cop_sign2),
    .cop_te1(cop_te1), .cop_te2(cop_te2),
    .cop_mant1(cop_mant1), .cop_mant2(cop_mant2),
    .cop_te_out(cop_te_out), .cop_frac_out(cop_frac_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_te(out_te), .out_frac(out_frac), .out_id(out_id), .out_tag(out_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OP_SIZE-1:0] op;
    logic               s1;
    logic               s2;
    logic [TE-1:0]      te1;
    logic [TE-1:0]      te2;
    logic [MS-1:0]      m1;
    logic [MS-1:0]      m2;
    logic [TAG_W-1:0]   tag;
    logic               id;
  } rec_t;

  // Stand-in core_op: an arbitrary but deterministic mix of its inputs.
  function automatic logic [TE-1:0] ref_te(input rec_t r);
    return r.te1 ^ {r.te2[TE-2:0], r.s2} ^ TE'(r.op);
  endfunction
  function automatic logic [FS-1:0] ref_frac(input rec_t r);
    return {r.m1, r.m2} ^ {FS{r.s1}};
  endfunction
  function automatic logic [63:0] cop_of(input rec_t r);
    return 64'({r.op, r.s1, r.s2, r.te1, r.te2, r.m1, r.m2});
  endfunction
  function automatic bit long_op(input logic [OP_SIZE-1:0] op);
    return !(op == ADD || op == SUB || op == MUL);
  endfunction

  rec_t core_in;
  always_comb begin
    core_in      = '0;
    core_in.op   = cop_op;
    core_in.s1   = cop_sign1;
    core_in.s2   = cop_sign2;
    core_in.te1  = cop_te1;
    core_in.te2  = cop_te2;
    core_in.m1   = cop_mant1;
    core_in.m2   = cop_mant2;
    cop_te_out   = ref_te(core_in);
    cop_frac_out = ref_frac(core_in);
  end

  logic [63:0] cop_now;
  assign cop_now = 64'({cop_op, cop_sign1, cop_sign2, cop_te1, cop_te2, cop_mant1, cop_mant2});

  int n_checks = 0;
  int n_err    = 0;
  int n_del    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester sources and stimulus knobs.
  rec_t cur [2];
  bit   cur_v [2];
  int   p_val [2];
  int   p_rdy;
  int   mode;

  // Reference model: one issue slot with a remaining-occupancy count, one output slot.
  bit   m_iss_v, m_out_v;
  int   m_left;
  int   m_rr;
  rec_t m_iss, m_out;

  function automatic rec_t gen(input int i, input int md);
    rec_t r;
    case (md)
      0: begin
        case ($urandom_range(2))
          0:       r.op = ADD;
          1:       r.op = SUB;
          default: r.op = MUL;
        endcase
      end
      1:       r.op = MUL;
      2:       r.op = DIV;
      3:       r.op = OP_SIZE'($urandom_range(7));
      default: r.op = ADD;
    endcase
    r.s1  = 1'($urandom_range(1));
    r.s2  = 1'($urandom_range(1));
    r.te1 = TE'($urandom);
    r.te2 = TE'($urandom);
    r.m1  = MS'($urandom);
    r.m2  = MS'($urandom);
    r.tag = TAG_W'($urandom);
    r.id  = 1'(i);
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < 2; i++)
      if (!cur_v[i] && ($urandom_range(99) < 32'(p_val[i]))) begin
        cur[i]   = gen(i, mode);
        cur_v[i] = 1'b1;
      end
    req_valid = {cur_v[1], cur_v[0]};
    req_op    = {cur[1].op,  cur[0].op};
    req_sign1 = {cur[1].s1,  cur[0].s1};
    req_sign2 = {cur[1].s2,  cur[0].s2};
    req_te1   = {cur[1].te1, cur[0].te1};
    req_te2   = {cur[1].te2, cur[0].te2};
    req_mant1 = {cur[1].m1,  cur[0].m1};
    req_mant2 = {cur[1].m2,  cur[0].m2};
    req_tag   = {cur[1].tag, cur[0].tag};
    out_ready = ($urandom_range(99) < 32'(p_rdy));
  endtask

  task automatic cycle();
    bit       any, in_rdy, adv, acc;
    int       g;
    logic [1:0] exp_rdy;
    @(negedge clk);
    drive();
    #1;
    adv    = m_iss_v && (m_left == 1) && (!m_out_v || out_ready);
    in_rdy = !m_iss_v || adv;
    any    = cur_v[0] || cur_v[1];
    g      = (cur_v[0] && cur_v[1]) ? m_rr : (cur_v[1] ? 1 : 0);
    acc    = any && in_rdy;
    exp_rdy = acc ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("busy", 64'(busy), 64'(m_iss_v || m_out_v));
    check("out_valid", 64'(out_valid), 64'(m_out_v));
    if (m_out_v) begin
      check("out_te", 64'(out_te), 64'(ref_te(m_out)));
      check("out_frac", 64'(out_frac), 64'(ref_frac(m_out)));
      check("out_id", 64'(out_id), 64'(m_out.id));
      check("out_tag", 64'(out_tag), 64'(m_out.tag));
      if (out_ready) n_del++;
    end
    if (m_iss_v) check("cop_inputs", cop_now, cop_of(m_iss));
    if (adv) begin
      m_out   = m_iss;
      m_out_v = 1'b1;
    end else if (out_ready) begin
      m_out_v = 1'b0;
    end
    if (acc) begin
      m_iss    = cur[g];
      m_iss_v  = 1'b1;
      m_left   = long_op(cur[g].op) ? DIV_CYCLES : 1;
      cur_v[g] = 1'b0;
      m_rr     = 1 - g;
    end else if (adv) begin
      m_iss_v = 1'b0;
    end else if (m_iss_v && m_left > 1) begin
      m_left--;
    end
    @(posedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_cop"}, cop_now, 64'd0);
    check({tag, "_out_data"}, 64'({out_te, out_frac, out_id, out_tag}), 64'd0);
  endtask

  task automatic run(input int cycles, input int md, input int pv0, input int pv1, input int pr);
    mode = md; p_val[0] = pv0; p_val[1] = pv1; p_rdy = pr;
    for (int k = 0; k < cycles; k++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1;
    cur[0] = '0; cur[1] = '0; cur_v[0] = 1'b0; cur_v[1] = 1'b0;
    p_val[0] = 0; p_val[1] = 0; p_rdy = 0; mode = 0;
    drive();
    req_valid = 2'b11;
    m_iss_v = 1'b0; m_out_v = 1'b0; m_left = 0; m_rr = 0;
    m_iss = '0; m_out = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    req_valid = 2'b00;
    rst = 1'b0;

    // Single requester ADD with fixed operands.
    cur[0] = gen(0, 4);
    cur[0].te1 = TE'(3); cur[0].te2 = TE'(1); cur[0].tag = TAG_W'(5);
    cur_v[0] = 1'b1;
    run(20, 4, 100, 0, 100);
    // Both requesters saturating with MUL: alternating grants, one result/cycle.
    run(40, 1, 100, 100, 100);
    // DIVs mixed with short ops from both sides.
    run(40, 2, 60, 100, 100);
    run(40, 0, 50, 50, 100);
    // Heavy output back-pressure with continuous ADDs.
    run(80, 4, 100, 100, 30);

    // Reset in the second cycle of a DIV hold window.
    found = 1'b0;
    mode = 2; p_val[0] = 100; p_val[1] = 100; p_rdy = 100;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle();
      if (m_iss_v && m_left == DIV_CYCLES - 1 && long_op(m_iss.op)) found = 1'b1;
    end
    check("div_hold_reached", 64'(found), 64'd1);
    #2 rst = 1'b1;
    #1;
    reset_checks("midrst");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    m_iss_v = 1'b0; m_out_v = 1'b0; m_left = 0; m_rr = 0;

    // Everything including illegal encodings, random back-pressure.
    run(400, 3, 70, 70, 70);
    run(20, 0, 0, 0, 100);
    check("delivered_count", 64'(n_del > 100), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
